// File: rtl/udp_tx.sv
// udp_tx: GMII transmit framer that wraps a payload in Ethernet II / IPv4 / UDP headers.
// Optional feature macro: UDP_TX_CRC_EN appends the Ethernet FCS internally; without it the FCS is added downstream.
module udp_tx #(
    parameter logic [47:0] BOARD_MAC     = 48'h001122334455,
    parameter logic [31:0] BOARD_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC       = 48'hffffffffffff,
    parameter logic [31:0] DES_IP        = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [15:0] BOARD_PORTNUM = 16'd1010,
    parameter logic [15:0] DES_PORTNUM   = 16'd1010
) (
    input  logic        i_gmii_tx_clk,
    input  logic        i_sys_rst,
    input  logic        i_tx_start,
    input  logic [15:0] i_tx_byte_num,
    input  logic [7:0]  i_tx_data,
    output logic        o_tx_req,
    output logic        o_gmii_tx_en,
    output logic [7:0]  o_gmii_tx_data,
    output logic        o_tx_done,
    output logic        o_busy
);

    localparam logic [15:0] MAX_LEN     = 16'd1472;
    localparam logic [15:0] MIN_PAYLOAD = 16'd18;

    typedef enum logic [3:0] {
        IDLE, CHECKSUM, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, TX_DATA, PAD, FCS, IFG
    } state_t;

    state_t      state_q, state_d, after_payload;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ident_q, ident_d;
    logic [15:0] req_left_q, req_left_d;
    logic [19:0] sum_q, sum_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] fold2;
    logic        req_q, req_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [15:0]       ip_total_len, udp_len;
    logic [0:13][7:0]  eth_b;
    logic [0:19][7:0]  ip_b;
    logic [0:7][7:0]   udp_b;

    assign ip_total_len = len_q + 16'd28;
    assign udp_len      = len_q + 16'd8;
    assign eth_b = {DES_MAC, BOARD_MAC, 16'h0800};
    assign ip_b  = {8'h45, 8'h00, ip_total_len, ident_q, 16'h4000, 8'h40, 8'h11,
                    csum_q, BOARD_IP, DES_IP};
    assign udp_b = {BOARD_PORTNUM, DES_PORTNUM, udp_len, 16'h0000};
    assign fold2 = sum_q[15:0] + {12'h000, sum_q[19:16]};

`ifdef UDP_TX_CRC_EN
    logic [31:0]      crc_q, crc_d;
    logic [3:0][7:0]  fcs_b;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign fcs_b         = ~crc_q;
    assign after_payload = FCS;
`else
    assign after_payload = IFG;
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        len_d      = len_q;
        ident_d    = ident_q;
        sum_d      = sum_q;
        csum_d     = csum_q;
        req_left_d = req_left_q;
        req_d      = 1'b0;
        en_d       = 1'b0;
        data_d     = 8'h00;
        done_d     = 1'b0;
        busy_d     = busy_q;

        // Requests lead the bus by two cycles to cover the source's read latency.
        if (req_left_q != 16'd0) begin
            req_d      = 1'b1;
            req_left_d = req_left_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (i_tx_start && i_tx_byte_num != 16'd0 && i_tx_byte_num <= MAX_LEN) begin
                    len_d   = i_tx_byte_num;
                    busy_d  = 1'b1;
                    state_d = CHECKSUM;
                end
            end
            CHECKSUM: begin
                case (cnt_q[1:0])
                    2'd0: sum_d = 20'h04500 + {4'h0, ip_total_len} + {4'h0, ident_q}
                                + 20'h04000 + 20'h04011
                                + {4'h0, BOARD_IP[31:16]} + {4'h0, BOARD_IP[15:0]}
                                + {4'h0, DES_IP[31:16]} + {4'h0, DES_IP[15:0]};
                    2'd1: sum_d = {4'h0, sum_q[15:0]} + {16'h0000, sum_q[19:16]};
                    default: begin
                        csum_d  = ~fold2;
                        state_d = PREAMBLE;
                        cnt_d   = 16'd0;
                    end
                endcase
            end
            PREAMBLE: begin
                en_d   = 1'b1;
                data_d = (cnt_q[2:0] == 3'd7) ? 8'hD5 : 8'h55;
                if (cnt_q == 16'd7) begin
                    state_d = ETH_HEAD;
                    cnt_d   = 16'd0;
                end
            end
            ETH_HEAD: begin
                en_d   = 1'b1;
                data_d = eth_b[cnt_q[3:0]];
                if (cnt_q == 16'd13) begin
                    state_d = IP_HEAD;
                    cnt_d   = 16'd0;
                end
            end
            IP_HEAD: begin
                en_d   = 1'b1;
                data_d = ip_b[cnt_q[4:0]];
                if (cnt_q == 16'd19) begin
                    state_d = UDP_HEAD;
                    cnt_d   = 16'd0;
                end
            end
            UDP_HEAD: begin
                en_d   = 1'b1;
                data_d = udp_b[cnt_q[2:0]];
                if (cnt_q == 16'd6) begin
                    req_d      = 1'b1;
                    req_left_d = len_q - 16'd1;
                end
                if (cnt_q == 16'd7) begin
                    state_d = TX_DATA;
                    cnt_d   = 16'd0;
                end
            end
            TX_DATA: begin
                en_d   = 1'b1;
                data_d = i_tx_data;
                if (cnt_q == len_q - 16'd1) begin
                    // PAD keeps counting from len so it stops at the minimum payload size.
                    if (len_q < MIN_PAYLOAD) begin
                        state_d = PAD;
                    end else begin
                        state_d = after_payload;
                        cnt_d   = 16'd0;
                    end
                end
            end
            PAD: begin
                en_d = 1'b1;
                if (cnt_q == MIN_PAYLOAD - 16'd1) begin
                    state_d = after_payload;
                    cnt_d   = 16'd0;
                end
            end
`ifdef UDP_TX_CRC_EN
            FCS: begin
                en_d   = 1'b1;
                data_d = fcs_b[cnt_q[1:0]];
                if (cnt_q == 16'd3) begin
                    state_d = IFG;
                    cnt_d   = 16'd0;
                end
            end
`endif
            IFG: begin
                if (cnt_q == 16'd12) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ident_d = ident_q + 16'd1;
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

`ifdef UDP_TX_CRC_EN
        crc_d = crc_q;
        if (state_q == PREAMBLE) begin
            crc_d = 32'hFFFFFFFF;
        end else if (state_q inside {ETH_HEAD, IP_HEAD, UDP_HEAD, TX_DATA, PAD}) begin
            crc_d = crc32_byte(crc_q, data_d);
        end
`endif
    end

    always_ff @(posedge i_gmii_tx_clk) begin
        if (i_sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            len_q      <= 16'd0;
            ident_q    <= 16'd0;
            req_left_q <= 16'd0;
            sum_q      <= 20'd0;
            csum_q     <= 16'd0;
            req_q      <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UDP_TX_CRC_EN
            crc_q      <= 32'hFFFFFFFF;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ident_q    <= ident_d;
            req_left_q <= req_left_d;
            sum_q      <= sum_d;
            csum_q     <= csum_d;
            req_q      <= req_d;
            en_q       <= en_d;
            data_q     <= data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
`ifdef UDP_TX_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign o_tx_req       = req_q;
    assign o_gmii_tx_en   = en_q;
    assign o_gmii_tx_data = data_q;
    assign o_tx_done      = done_q;
    assign o_busy         = busy_q;

endmodule
